// File: rtl/resp_timer_pkg.sv
// rtl/resp_timer_pkg.sv - shared state encodings and default sizing for the response timer
package resp_timer_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_COUNT = 1'b1
    } state_t;

    localparam int          DEF_CNT_W       = 32;
    localparam logic [31:0] DEF_TIMEOUT     = 32'd5000000;
    localparam int          DEF_SYNC_STAGES = 2;

endpackage

// File: rtl/resp_timer_sync_fall.sv
// rtl/resp_timer_sync_fall.sv - async line synchroniser with registered falling-edge pulse
module resp_timer_sync_fall #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   line_prev;
    logic                   line_sync;

    assign line_sync = sync_q[SYNC_STAGES-1];

    // Shift the line through the synchroniser; everything presets to idle-high so reset never fakes an edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q    <= '1;
            line_prev <= 1'b1;
            fall      <= 1'b0;
        end else begin
            sync_q    <= {sync_q[SYNC_STAGES-2:0], din};
            line_prev <= line_sync;
            fall      <= line_prev & ~line_sync;
        end
    end

endmodule

// File: rtl/resp_timer.sv
// rtl/resp_timer.sv - counts cycles from arm pulse to first start bit on the target TX line
module resp_timer
    import resp_timer_pkg::*;
#(
    parameter int               CNT_W       = DEF_CNT_W,
    parameter logic [CNT_W-1:0] TIMEOUT     = CNT_W'(DEF_TIMEOUT),
    parameter int               SYNC_STAGES = DEF_SYNC_STAGES
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             resp_din,
    output logic             busy,
    output logic [CNT_W-1:0] cycles,
    output logic             cycles_valid,
    output logic             timeout
);

    localparam logic [CNT_W-1:0] LAST_CNT = TIMEOUT - 1'b1;

    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] counter;
    logic             fall;
    logic             hit;
    logic             expire;

    resp_timer_sync_fall #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync_fall (
        .clk  (clk),
        .rst  (rst),
        .din  (resp_din),
        .fall (fall)
    );

    // Next-state: arm from IDLE, finish on an edge (which beats the timeout in the same cycle).
    always_comb begin
        state_d = state_q;
        hit     = 1'b0;
        expire  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_COUNT;
                end
            end
            ST_COUNT: begin
                if (fall) begin
                    hit     = 1'b1;
                    state_d = ST_IDLE;
                end else if (counter == LAST_CNT) begin
                    expire  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State, counter and result register; counter is held at zero outside COUNT so arming starts at 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            counter      <= '0;
            busy         <= 1'b0;
            cycles       <= '0;
            cycles_valid <= 1'b0;
            timeout      <= 1'b0;
        end else begin
            state_q      <= state_d;
            busy         <= (state_d == ST_COUNT);
            cycles_valid <= hit | expire;
            timeout      <= expire;
            if (state_q == ST_COUNT) begin
                counter <= counter + 1'b1;
            end else begin
                counter <= '0;
            end
            if (hit) begin
                cycles <= counter;
            end else if (expire) begin
                cycles <= TIMEOUT;
            end
        end
    end

endmodule
